// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: data width, reset PC, the fetch entry format
// and the canonical NOP.
package rv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Show-ahead FIFO with occupancy count and synchronous clear; the head entry is
// read straight from the storage registers. Depth need not be a power of two.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop frees the slot, so push is allowed at full when popping together.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, stale-response dropping
// and the IF/ID buffer. Define IF_MISALIGN_CHECK_EN to flag misaligned redirects.
module if_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2,
  parameter int              MAX_OUTST  = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            fetch_misaligned
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTST + 1);

  logic [XLEN-1:0] pc_q, pc_d, redir_pc, tag_pc;
  logic [TCW-1:0]  outst, drop_cnt_q, drop_cnt_d;
  logic [FCW-1:0]  fifo_count;
  fetch_entry_t    push_entry, head_entry;
  logic            accept, fifo_push, fifo_pop, fetch_block;

  // Requests in flight equal the tag queue occupancy, so it doubles as the counter.
  assign imem_req_valid = !rst && !redirect_valid && !fetch_block
                          && ((int'(outst) + int'(fifo_count)) < FIFO_DEPTH)
                          && (int'(outst) < MAX_OUTST);
  assign imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;

  assign fifo_push   = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign if_id_valid = (fifo_count != '0);
  assign fifo_pop    = if_id_valid && !id_stall;
  assign push_entry  = '{instr: imem_rsp_data, pc: tag_pc};
  assign if_id_instr = head_entry.instr;
  assign if_id_pc    = head_entry.pc;

`ifdef IF_MISALIGN_CHECK_EN
  logic misaligned_q;

  assign redir_pc         = redirect_pc;
  assign fetch_block      = misaligned_q;
  assign fetch_misaligned = misaligned_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 misaligned_q <= 1'b0;
    else if (redirect_valid) misaligned_q <= |redirect_pc[1:0];
  end
`else
  assign redir_pc         = redirect_pc & ~32'h3;
  assign fetch_block      = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redir_pc;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_cnt_d = outst - TCW'(imem_rsp_valid);
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - TCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  if_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .push_i  (accept),
    .data_i  (pc_q),
    .pop_i   (imem_rsp_valid),
    .data_o  (tag_pc),
    .count_o (outst)
  );

  if_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_ifid_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect_valid),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: an in-order imem model with variable latency
// and an instruction-stream reference model tagged by redirect epoch.
module tb_if_stage;

  localparam int FIFO_DEPTH = 2;
  localparam int MAX_OUTST  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_stall         (id_stall),
    .if_id_valid      (if_id_valid),
    .if_id_instr      (if_id_instr),
    .if_id_pc         (if_id_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        mq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc, lat, last_due, epoch, buf_cnt;
  logic [31:0] fetch_ptr, exp_pc;
  logic        mis_exp;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cyc       = 0;
    last_due  = -1;
    epoch     = 0;
    buf_cnt   = 0;
    fetch_ptr = 32'h0;
    exp_pc    = 32'h0;
    mis_exp   = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_if_id_valid", if_id_valid, 0);
    check("rst_if_id_instr", if_id_instr, 0);
    check("rst_if_id_pc", if_id_pc, 0);
    check("rst_misaligned", fetch_misaligned, 0);
  endtask

  // Called at a falling edge: drive one cycle, check, advance the model.
  task automatic step(input logic rdy, input logic stall, input logic redir, input logic [31:0] rpc);
    int          inflight, due;
    logic        rsp, exp_rv, acc, push, pop;
    logic [31:0] tgt;
    req_t        e;
    imem_req_ready = rdy;
    id_stall       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inflight       = mq.size();
    rsp            = (mq.size() != 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(mq[0].addr) : $urandom();
    #1;
    exp_rv = !redir && (inflight + buf_cnt < FIFO_DEPTH) && (inflight < MAX_OUTST) && !mis_exp;
    check("req_valid", imem_req_valid, exp_rv);
    if (imem_req_valid) check("req_addr", imem_req_addr, fetch_ptr & ~32'h3);
    check("if_id_valid", if_id_valid, buf_cnt != 0);
    if (buf_cnt != 0) begin
      check("if_id_pc", if_id_pc, exp_pc);
      check("if_id_instr", if_id_instr, memf(exp_pc));
    end
    check("misaligned", fetch_misaligned, mis_exp);

    acc  = imem_req_valid && rdy;
    pop  = (buf_cnt != 0) && !stall && !redir;
    push = 1'b0;
    if (rsp) begin
      e    = mq.pop_front();
      push = (e.epoch == epoch) && !redir;
    end
    if (acc) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back('{addr: imem_req_addr, due: due, epoch: epoch});
      last_due  = due;
      fetch_ptr = fetch_ptr + 32'd4;
    end
    if (pop) begin
      $display("cycle %0d: ID takes pc=%h instr=%h", cyc, exp_pc, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
`ifdef IF_MISALIGN_CHECK_EN
      tgt     = rpc;
      mis_exp = |rpc[1:0];
`else
      tgt     = rpc & ~32'h3;
`endif
      $display("cycle %0d: redirect to %h", cyc, tgt);
      epoch++;
      buf_cnt   = 0;
      fetch_ptr = tgt;
      exp_pc    = tgt;
    end else begin
      buf_cnt = buf_cnt + int'(push) - int'(pop);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy, input logic stall);
    for (int i = 0; i < n; i++) step(rdy, stall, 1'b0, 32'h0);
  endtask

  initial begin
    int hit;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_stall       = 1'b0;
    lat            = 1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Streaming at latency 1, then a 5-cycle stall with the buffer filling.
    run(20, 1'b1, 1'b0);
    run(5, 1'b1, 1'b1);
    run(10, 1'b1, 1'b0);

    // Latency 3 with requests in flight, then redirect.
    lat = 3;
    run(6, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    run(14, 1'b1, 1'b0);

    // Redirect landing on a response cycle while ID is stalled.
    hit = 0;
    for (int i = 0; i < 20 && hit == 0; i++) begin
      if (mq.size() != 0 && mq[0].due <= cyc) hit = 1;
      else step(1'b1, 1'b0, 1'b0, 32'h0);
    end
    check("rsp_redirect_found", hit, 1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    run(12, 1'b1, 1'b0);

    // PC wrap at the top of the address space.
    lat = 1;
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run(8, 1'b1, 1'b0);

    // Misaligned redirect followed by an aligned one.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0102);
    run(5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    run(8, 1'b1, 1'b0);

    // Back-to-back redirects.
    lat = 2;
    run(4, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0400);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0500);
    run(10, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lat = $urandom_range(1, 4);
      step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 30) == 0,
           $urandom & 32'h0000_FFFF);
    end

    // Reset mid-operation; memory is reset with the stage.
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lat = 1;
    run(12, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction Fetch stage: owns the PC, issues word fetches to instruction memory and buffers returned instructions.
- Presents {instruction, pc} pairs to the ID stage through a show-ahead IF/ID buffer.
- Accepts redirects (branch/JAL/JALR) from EX and stalls from the hazard unit.
- Discards in-flight fetches made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, IF/ID instruction buffer entries (power of 2, >=2).
- MAX_OUTST, 2, maximum imem requests in flight (1..3).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset asynchronous, active-high.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; in order, latency >=1; never back-pressured.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  EX-stage control transfer.
- redirect_pc  in  32  new PC.
- id_stall  in  1  ID cannot accept; hold head entry.
- if_id_valid  out  1  head entry valid.
- if_id_instr  out  32  instruction to ID stage (instruction_in).
- if_id_pc  out  32  its PC (pc_curr_if).
- fetch_misaligned  out  1  misaligned redirect flag; 0 unless feature enabled.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty, fetch_misaligned=0.
  - Outputs during reset: imem_req_valid=0, if_id_valid=0, if_id_instr=0, if_id_pc=0.
- Credit rule: imem_req_valid = !rst && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH) && (outstanding < MAX_OUTST).
  - Every response is therefore guaranteed a FIFO slot.
- imem_req_addr = {pc[31:2],2'b00}.
  - req_valid/addr may change while not accepted; this is not a sticky handshake.
- Accept (valid && ready): pc <= pc+4, wrapping 32'hFFFF_FFFC -> 0.
  - Each accepted request also pushes its PC into a pc-tag queue of depth MAX_OUTST.
- outstanding: +1 on accept, -1 on response; both in the same cycle leaves it unchanged.
- Response handling:
  - drop_cnt>0: drop_cnt-1, tag popped, data discarded.
  - Otherwise: push {imem_rsp_data, tag} into FIFO.
- Output: if_id_* = FIFO head, combinational from storage registers; if_id_valid = fifo_count != 0.
  - Pop when if_id_valid && !id_stall.
  - Push and pop in the same cycle is legal at any count, including full.
  - With id_stall=1, if_id_instr/pc are held stable.
- Redirect (highest priority, ignores id_stall):
  - pc <= redirect_pc; FIFO cleared (if_id_valid=0 next cycle); no request issued this cycle.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0) + (drop_cnt counted inclusively). Net effect: every request accepted before the redirect cycle is dropped, including any with a response arriving in the redirect cycle.
  - Tag queue is retained so dropped responses still pop their tags.
- Latency from reset release:
  - Cycle 0: request RESET_PC.
  - Response at earliest cycle 1.
  - if_id_valid at earliest cycle 2.
- Redirect to first valid output: minimum 3 cycles (redirect, request, response, output).
- Back-to-back redirects: the latest redirect wins; drop_cnt is recomputed each time.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset must not occur (memory is reset together with the stage).

Optional Feature:
- Macro IF_MISALIGN_CHECK_EN.
- Enabled:
  - redirect_pc[1:0]!=0 sets fetch_misaligned (sticky) and loads pc.
  - No requests are issued while fetch_misaligned=1.
  - The next aligned redirect clears it.
- Disabled:
  - redirect_pc[1:0] forced to 00.
  - fetch_misaligned tied 0.

Decomposition:
- Shared package rv_pipe_pkg: XLEN=32, RESET_PC default, type fetch_entry_t {instr, pc}, NOP constant 32'h0000_0013.
- One sub-module: if_fifo, a parametrised show-ahead FIFO with count and synchronous clear.
  - Instantiated for both the IF/ID buffer and the pc-tag queue.

Test Plan:
- Reset release, imem latency 1, ready=1, id_stall=0 -> requests to 0x0,0x4,0x8,...; if_id_valid from cycle 2; pc sequence 0x0,0x4,... with matching instr.
- id_stall=1 for 5 cycles with FIFO filling -> imem_req_valid drops once outstanding+count=2; if_id_instr/pc unchanged; no loss or duplication after release.
- Latency 3, 2 in flight, redirect_pc=0x100 -> both stale responses dropped; next if_id_pc=0x100, then 0x104.
- Redirect in the same cycle as a response and with a stall asserted -> response dropped, FIFO empty next cycle, fetch restarts at target.
- pc=0xFFFF_FFFC via redirect -> next request addr 0x0000_0000.
- IF_MISALIGN_CHECK_EN defined, redirect_pc=0x102 -> fetch_misaligned=1, no requests; redirect 0x200 -> flag cleared, fetch at 0x200.
